// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, mem_ctl field positions, size codes and FSM
//               states for the memory-access pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int REG_W       = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int MEM_CTL_W   = 6;
    localparam int EX2MEM_W    = 108;
    localparam int MEM2WB_W    = 70;

    localparam int MEM_LD      = 5;
    localparam int MEM_ST      = 4;
    localparam int MEM_SZ_HI   = 3;
    localparam int MEM_SZ_LO   = 2;
    localparam int MEM_UNS     = 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mem_state_e;

    typedef struct packed {
        logic [MEM_CTL_W-1:0]  mem_ctl;
        logic [REG_W-1:0]      st_data;
        logic [REG_W-1:0]      exe_result;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  rd_we;
        logic [REG_W-1:0]      pc;
    } ex2mem_bus_t;

    // The undefined size code 2'b11 is handled as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// Module      : mem_align
// Description : Combinational lane logic: store byte enables and replicated
//               write data, load lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [REG_W-1:0] st_data_i,
    input  logic [REG_W-1:0] rdata_i,
    output logic [3:0]       be_o,
    output logic [REG_W-1:0] wdata_o,
    output logic [REG_W-1:0] ld_data_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata_i[8*addr_lo_i +: 8];
        lane_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        be_o      = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = uns_i ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                be_o      = 4'b0011 << addr_lo_i;
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = uns_i ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            end
            default: begin
                be_o      = 4'b1111;
                wdata_o   = st_data_i;
                ld_data_o = rdata_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage: one data-SRAM transaction per instruction
//               over req/gnt/rvalid, load alignment, MEM->WB bus generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [EX2MEM_W-1:0]   ex2mem_bus_ri,
    input  logic                  ctl_mem_valid_i,
    input  logic                  ctl_mem_go_i,
    output logic                  ctl_mem_over_o,
    output logic [REG_ADDR_W-1:0] ctl_mem_dest_o,
    output logic [REG_W-1:0]      ctl_mem_pc_o,
    output logic                  ctl_mem_ale_o,
    output logic [MEM2WB_W-1:0]   mem2wb_bus_o,
    output logic                  dmem_req_o,
    output logic [3:0]            dmem_be_o,
    output logic [REG_W-1:0]      dmem_addr_o,
    output logic [REG_W-1:0]      dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [REG_W-1:0]      dmem_rdata_i
);

    ex2mem_bus_t      bus;
    logic             is_load;
    logic             is_store;
    logic             is_mem;
    logic [1:0]       size;
    logic             misaligned;
    logic             ale;
    logic [3:0]       al_be;
    logic [REG_W-1:0] al_wdata;
    logic [REG_W-1:0] al_ld_data;
    logic [REG_W-1:0] wb_data;
    logic             unused_ctl_rsvd;

    mem_state_e       state_q, state_d;
    logic [REG_W-1:0] rdata_q, rdata_d;

    assign bus             = ex2mem_bus_ri;
    assign unused_ctl_rsvd = bus.mem_ctl[0];

    // Load wins when both load and store are set.
    assign is_load    = bus.mem_ctl[MEM_LD];
    assign is_store   = bus.mem_ctl[MEM_ST] & ~is_load;
    assign is_mem     = is_load | is_store;
    assign size       = bus.mem_ctl[MEM_SZ_HI:MEM_SZ_LO];
    assign misaligned = is_misaligned(size, bus.exe_result[1:0]);
    assign ale        = ctl_mem_valid_i & is_mem & misaligned;

    mem_align u_mem_align (
        .size_i    (size),
        .uns_i     (bus.mem_ctl[MEM_UNS]),
        .addr_lo_i (bus.exe_result[1:0]),
        .st_data_i (bus.st_data),
        .rdata_i   (rdata_q),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl_mem_valid_i && is_mem && !misaligned)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (dmem_gnt_i)
                    state_d = is_load ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    rdata_d = dmem_rdata_i;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ctl_mem_go_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request and payload come from state and the stable bus only, never from gnt.
    always_comb begin
        dmem_req_o     = (state_q == ST_REQ);
        dmem_be_o      = (dmem_req_o && is_store) ? al_be : 4'b0000;
        dmem_addr_o    = {bus.exe_result[REG_W-1:2], 2'b00};
        dmem_wdata_o   = al_wdata;
        ctl_mem_over_o = ctl_mem_valid_i & (~is_mem | misaligned | (state_q == ST_DONE));
        ctl_mem_ale_o  = ale;
        ctl_mem_dest_o = (ctl_mem_valid_i && bus.rd_we) ? bus.rd_addr : '0;
        ctl_mem_pc_o   = bus.pc;
        wb_data        = is_load ? al_ld_data : bus.exe_result;
        mem2wb_bus_o   = {bus.rd_addr, bus.rd_we & ~ale, wb_data, bus.pc};
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed scoreboard bench for mem_stage with request and
//               response monitors decoupled from stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [107:0] ex2mem_bus_ri = '0;
    logic         ctl_mem_valid_i = 1'b0;
    logic         ctl_mem_go_i = 1'b0;
    logic         ctl_mem_over_o;
    logic [4:0]   ctl_mem_dest_o;
    logic [31:0]  ctl_mem_pc_o;
    logic         ctl_mem_ale_o;
    logic [69:0]  mem2wb_bus_o;
    logic         dmem_req_o;
    logic [3:0]   dmem_be_o;
    logic [31:0]  dmem_addr_o;
    logic [31:0]  dmem_wdata_o;
    logic         dmem_gnt_i = 1'b0;
    logic         dmem_rvalid_i = 1'b0;
    logic [31:0]  dmem_rdata_i = 32'hA5A5A5A5;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex2mem_bus_ri   (ex2mem_bus_ri),
        .ctl_mem_valid_i (ctl_mem_valid_i),
        .ctl_mem_go_i    (ctl_mem_go_i),
        .ctl_mem_over_o  (ctl_mem_over_o),
        .ctl_mem_dest_o  (ctl_mem_dest_o),
        .ctl_mem_pc_o    (ctl_mem_pc_o),
        .ctl_mem_ale_o   (ctl_mem_ale_o),
        .mem2wb_bus_o    (mem2wb_bus_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [69:0] wb;
        bit          chk_wb;
        logic        ale;
        logic [4:0]  dest;
        int          lat;
        int          req_cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    resp_t resp_q[$];
    req_t  req_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_cnt = 0;
    int    op_start = 0;
    int    req_cycles = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [107:0] mk(input logic [5:0] c, input logic [31:0] s, input logic [31:0] e,
                                        input logic [4:0] r, input logic w, input logic [31:0] p);
        return {c, s, e, r, w, p};
    endfunction

    // Monitor: samples well after stimulus has settled in each low phase.
    always @(negedge clk) begin
        #3;
        if (rst_n && dmem_req_o) begin
            req_cycles++;
            if (req_q.size() == 0) begin
                chk("req_unexpected", 70'(dmem_req_o), 70'd0);
            end else begin
                chk("req_addr",  70'(dmem_addr_o),  70'(req_q[0].addr));
                chk("req_be",    70'(dmem_be_o),    70'(req_q[0].be));
                chk("req_wdata", 70'(dmem_wdata_o), 70'(req_q[0].wdata));
                if (dmem_gnt_i) void'(req_q.pop_front());
            end
        end
        if (ctl_mem_valid_i && ctl_mem_over_o && ctl_mem_go_i) begin
            if (resp_q.size() == 0) begin
                chk("over_unexpected", 70'(ctl_mem_over_o), 70'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("wb_rd",      70'(mem2wb_bus_o[69:64]), 70'(e.wb[69:64]));
                if (e.chk_wb)
                    chk("wb_data", 70'(mem2wb_bus_o[63:32]), 70'(e.wb[63:32]));
                chk("wb_pc",      70'(mem2wb_bus_o[31:0]),  70'(e.wb[31:0]));
                chk("ale",        70'(ctl_mem_ale_o),       70'(e.ale));
                chk("dest",       70'(ctl_mem_dest_o),      70'(e.dest));
                chk("ctl_pc",     70'(ctl_mem_pc_o),        70'(e.wb[31:0]));
                chk("latency",    70'(cyc_cnt - op_start),  70'(e.lat));
                chk("req_cycles", 70'(req_cycles),          70'(e.req_cyc));
            end
            req_cycles = 0;
        end
    end

    task automatic run_op(input logic [5:0] ctl, input logic [31:0] st, input logic [31:0] exe,
                          input logic [4:0] rd, input logic we, input logic [31:0] pc,
                          input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                          input int go_wait, input logic [31:0] exp_wb, input logic exp_ale,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input int exp_lat, input int exp_reqc);
        resp_t r;
        req_t  q;
        bit    done = 0;
        bit    pend = 0;
        int    reqc = 0;
        int    rvc = 0;
        int    overc = 0;

        @(negedge clk);
        ex2mem_bus_ri   = mk(ctl, st, exe, rd, we, pc);
        ctl_mem_valid_i = 1'b1;
        op_start        = cyc_cnt;
        r.wb      = {rd, we & ~exp_ale, exp_wb, pc};
        r.chk_wb  = !exp_ale;
        r.ale     = exp_ale;
        r.dest    = we ? rd : 5'd0;
        r.lat     = exp_lat;
        r.req_cyc = exp_reqc;
        resp_q.push_back(r);
        if (exp_reqc > 0) begin
            q.addr  = {exe[31:2], 2'b00};
            q.be    = exp_be;
            q.wdata = exp_wdata;
            req_q.push_back(q);
        end

        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (dmem_req_o) begin
                dmem_gnt_i = (reqc >= gnt_wait);
                reqc++;
            end
            if (pend) begin
                if (rvc >= rv_wait) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = rdata;
                end
                rvc++;
            end
            if (ctl_mem_over_o) begin
                ctl_mem_go_i = (overc >= go_wait);
                overc++;
            end
            @(posedge clk);
            if (ctl_mem_go_i) done = 1;
            if (dmem_gnt_i && ctl[5]) pend = 1;
            if (dmem_rvalid_i) pend = 0;
            @(negedge clk);
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = 32'hA5A5A5A5;
            ctl_mem_go_i  = 1'b0;
            if (done) ctl_mem_valid_i = 1'b0;
        end

        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: pc %h got no over/go completion, required completion in 60 cycles", pc);
            resp_q.delete();
            req_q.delete();
            ctl_mem_valid_i = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            req_cycles = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #2;
        chk("rst_req",  70'(dmem_req_o),     70'd0);
        chk("rst_be",   70'(dmem_be_o),      70'd0);
        chk("rst_over", 70'(ctl_mem_over_o), 70'd0);
        chk("rst_ale",  70'(ctl_mem_ale_o),  70'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //     ctl    st_data       exe           rd  we  pc            rdata         gw rw gow exp_wb        ale  be       wdata         lat reqc
        run_op(6'h00, 32'h0,        32'h00001234, 5,  1, 32'h00001000, 32'h0,         0, 0, 0, 32'h00001234, 0, 4'b0000, 32'h0,         0, 0);
        run_op(6'h18, 32'hDEADBEEF, 32'h00000100, 0,  0, 32'h00001004, 32'h0,         3, 0, 0, 32'h00000100, 0, 4'b1111, 32'hDEADBEEF, 5, 4);
        run_op(6'h20, 32'h0,        32'h00000203, 7,  1, 32'h00001008, 32'h80FFFFFF,  0, 0, 0, 32'hFFFFFF80, 0, 4'b0000, 32'h0,         3, 1);
        run_op(6'h22, 32'h0,        32'h00000203, 8,  1, 32'h0000100C, 32'h80FFFFFF,  0, 0, 0, 32'h00000080, 0, 4'b0000, 32'h0,         3, 1);
        run_op(6'h24, 32'h0,        32'h00000202, 9,  1, 32'h00001010, 32'hBEEF0000,  0, 0, 0, 32'hFFFFBEEF, 0, 4'b0000, 32'h0,         3, 1);
        run_op(6'h10, 32'h0000005A, 32'h00000201, 0,  0, 32'h00001014, 32'h0,         0, 0, 0, 32'h00000201, 0, 4'b0010, 32'h5A5A5A5A, 2, 1);
        run_op(6'h28, 32'h0,        32'h00000102, 3,  1, 32'h00001018, 32'h0,         0, 0, 0, 32'h0,        1, 4'b0000, 32'h0,         0, 0);
        run_op(6'h24, 32'h0,        32'h00000201, 4,  1, 32'h0000101C, 32'h0,         0, 0, 0, 32'h0,        1, 4'b0000, 32'h0,         0, 0);
        run_op(6'h14, 32'h1234ABCD, 32'h00000202, 0,  0, 32'h00001020, 32'h0,         0, 0, 0, 32'h00000202, 0, 4'b1100, 32'hABCDABCD, 2, 1);
        run_op(6'h28, 32'h0,        32'h00000300, 10, 1, 32'h00001024, 32'hCAFEF00D,  0, 2, 5, 32'hCAFEF00D, 0, 4'b0000, 32'h0,        10, 1);
        run_op(6'h26, 32'h0,        32'h00000302, 11, 1, 32'h00001028, 32'h80010000,  1, 1, 0, 32'h00008001, 0, 4'b0000, 32'h0,         5, 2);
        run_op(6'h38, 32'h55555555, 32'h00000400, 12, 1, 32'h0000102C, 32'h11223344,  0, 0, 0, 32'h11223344, 0, 4'b0000, 32'h55555555,  3, 1);

        // Reset while waiting for read data.
        begin
            req_t q;
            @(negedge clk);
            ex2mem_bus_ri   = mk(6'h28, 32'h0, 32'h00000500, 13, 1'b1, 32'h00002000);
            ctl_mem_valid_i = 1'b1;
            q.addr = 32'h00000500; q.be = 4'b0000; q.wdata = 32'h0;
            req_q.push_back(q);
            @(negedge clk);
            #1;
            chk("rst_test_req_up", 70'(dmem_req_o), 70'd1);
            dmem_gnt_i = dmem_req_o;
            @(negedge clk);
            dmem_gnt_i = 1'b0;
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_wait_req",  70'(dmem_req_o),     70'd0);
            chk("rst_wait_over", 70'(ctl_mem_over_o), 70'd0);
            chk("rst_wait_be",   70'(dmem_be_o),      70'd0);
            ctl_mem_valid_i = 1'b0;
            req_q.delete();
            req_cycles = 0;
            @(negedge clk);
            rst_n = 1'b1;
        end

        run_op(6'h28, 32'h0,        32'h00000504, 14, 1, 32'h00002004, 32'h0BADF00D,  0, 0, 0, 32'h0BADF00D, 0, 4'b0000, 32'h0,         3, 1);

        repeat (2) @(negedge clk);
        chk("resp_q_drained", 70'(resp_q.size()), 70'd0);
        chk("req_q_drained",  70'(req_q.size()),  70'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
